// File: rtl/nibble_serial_pkg.sv
// Shared constants, state encoding and sizing helpers for the nibble-serial add/sub.
package nibble_serial_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble index counter width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_cla.sv
// 4-bit carry-look-ahead adder slice with an explicit carry-in so that
// carries can be chained across clock cycles by the sequencer.
module cla_nibble_slice
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out,
  output logic                c_msb
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  // Generate/propagate look-ahead carries, all expressed from c_in directly.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[NIBBLE_W-1:0];
    c_out = c[NIBBLE_W];
    c_msb = c[NIBBLE_W-1];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-word adder/subtractor: sequences W-bit operands one nibble per clock
// (LSB first) through a 4-bit CLA slice, chaining the carry in a register.
module nibble_serial_addsub
  import nibble_serial_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        sel,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        c_out,
  output logic                        overflow
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       res_sh;
  logic [W-1:0]       res_shift;
  logic               sel_r;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               accept;
  logic               step;

  logic [NIBBLE_W-1:0] s_b;
  logic [NIBBLE_W-1:0] s_sum;
  logic                s_cout;
  logic                s_cmsb;

  // Subtraction feeds the inverted B nibble; the +1 comes in via carry_reg.
  assign s_b = b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{sel_r}};

  cla_nibble_slice u_slice (
    .a     (a_sh[NIBBLE_W-1:0]),
    .b     (s_b),
    .c_in  (carry_reg),
    .sum   (s_sum),
    .c_out (s_cout),
    .c_msb (s_cmsb)
  );

  // New sum nibble enters at the top so the LSB nibble ends at the bottom.
  generate
    if (NIBBLES == 1) begin : g_single
      assign res_shift = s_sum;
    end else begin : g_multi
      assign res_shift = {s_sum, res_sh[W-1:NIBBLE_W]};
    end
  endgenerate

  assign last      = (idx == IDX_W'(NIBBLES - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_sh;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-nibble shifting and final flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      sel_r     <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_sh      <= a;
      b_sh      <= b;
      sel_r     <= sel;
      carry_reg <= sel;
      idx       <= '0;
    end else if (step) begin
      a_sh      <= a_sh >> NIBBLE_W;
      b_sh      <= b_sh >> NIBBLE_W;
      res_sh    <= res_shift;
      carry_reg <= s_cout;
      idx       <= idx + IDX_W'(1);
      if (last) begin
        c_out    <= s_cout;
        overflow <= s_cmsb ^ s_cout;
      end
    end
  end

endmodule
